// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Purpose  : Fixed-latency instruction-fetch responder backed by a word RAM.
//             Accepts one fetch per cycle, answers RD_LAT cycles later in
//             order, flags misaligned/out-of-window fetches with a NOP word,
//             supports a program-load write port and a pipeline flush.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,  // byte address of word 0
  parameter int          MEM_WORDS = 4096,           // power of two
  parameter int          RD_LAT    = 2               // legal range 1..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rinst,
  input  logic [31:0] mem_rinst_addr,
  input  logic        flush,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata,
  output logic        mem_rinst_rvalid,
  output logic [31:0] mem_rinst_rdata,
  output logic        mem_rinst_err,
  output logic [31:0] rsp_cnt
);

  // Index width; a single-word memory still needs a one-bit index.
  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Window size in bytes, kept 34 bits wide so a 2^30-word memory still fits.
  localparam logic [33:0] C_MEM_BYTES = 34'(MEM_WORDS) << 2;
  localparam logic [31:0] C_NOP       = 32'h0000_0013;

  // --------------------------------------------------------------------------
  // Storage and pipeline state
  // --------------------------------------------------------------------------
  logic [31:0]      mem_q [MEM_WORDS];

  // Stage k holds the response that will be presented RD_LAT-k cycles later;
  // stage RD_LAT drives the outputs directly.
  logic [RD_LAT:1]  vld_q;
  logic [RD_LAT:1]  err_q;
  logic [31:0]      dat_q [1:RD_LAT];

  logic [31:0]      rsp_cnt_q;
  logic [31:0]      rsp_cnt_d;

  // --------------------------------------------------------------------------
  // Fetch address decode
  // --------------------------------------------------------------------------
  logic [31:0]      w_rd_off;
  logic             w_rd_err;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_accept;

  // Offset arithmetic is modulo 2^32, so an address below MEM_BASE wraps to a
  // huge offset and naturally lands outside the window.
  assign w_rd_off = mem_rinst_addr - MEM_BASE;
  assign w_rd_err = (mem_rinst_addr[1:0] != 2'b00) || ({2'b00, w_rd_off} >= C_MEM_BYTES);
  assign w_rd_idx = w_rd_off[IDX_W+1:2];

  // A request presented together with a flush is dropped along with the
  // in-flight ones.
  assign w_accept = mem_rinst && !flush;

  // --------------------------------------------------------------------------
  // Program-load write decode
  // --------------------------------------------------------------------------
  logic [31:0]      w_wr_off;
  logic             w_wr_hit;
  logic [IDX_W-1:0] w_wr_idx;

  // Byte-lane bits of the load address carry no meaning; only the word
  // number is checked against the window.
  assign w_wr_off = init_addr - MEM_BASE;
  assign w_wr_hit = ({2'b00, w_wr_off[31:2]} < 32'(MEM_WORDS));
  assign w_wr_idx = w_wr_off[IDX_W+1:2];

  logic w_unused_bits;
  assign w_unused_bits = ^w_wr_off[1:0];

  // --------------------------------------------------------------------------
  // Memory array: no reset so a loaded program survives a core reset. The
  // read in the pipeline block samples the pre-write value (read-first).
  // --------------------------------------------------------------------------
  // Program-load write port, blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && init_we && w_wr_hit) begin
      mem_q[w_wr_idx] <= init_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline: valid bits always advance; err/data only load when a
  // valid entry moves in, so the output stage holds its last response while
  // rvalid is low.
  // --------------------------------------------------------------------------
  // Stage 1 performs the registered memory read; later stages shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= RD_LAT; k++) begin
        vld_q[k] <= 1'b0;
        err_q[k] <= 1'b0;
        dat_q[k] <= 32'h0000_0000;
      end
    end else begin
      vld_q[1] <= w_accept;
      if (w_accept) begin
        err_q[1] <= w_rd_err;
        dat_q[1] <= w_rd_err ? C_NOP : mem_q[w_rd_idx];
      end
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1] && !flush;
        if (vld_q[k-1] && !flush) begin
          err_q[k] <= err_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response counter: steps once for every cycle a response is on the bus.
  // --------------------------------------------------------------------------
  // Next-count logic; the 32-bit add wraps naturally.
  always_comb begin
    rsp_cnt_d = rsp_cnt_q;
    if (vld_q[RD_LAT]) begin
      rsp_cnt_d = rsp_cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_cnt_q <= 32'h0000_0000;
    end else begin
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_rinst_rvalid = vld_q[RD_LAT];
  assign mem_rinst_rdata  = dat_q[RD_LAT];
  assign mem_rinst_err    = err_q[RD_LAT];
  assign rsp_cnt          = rsp_cnt_q;

endmodule
`default_nettype wire
